// File: rtl/mux3_rr_arbiter_pkg.sv
// Shared encodings for the 3-way round-robin mux arbiter: select codes,
// FSM states and a one-hot to select converter.
package mux3_rr_arbiter_pkg;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // A zero vector maps to SEL_A; callers only pass a real one-hot pick.
  function automatic logic [1:0] sel_of(input logic [2:0] onehot);
    logic [1:0] code;
    code = SEL_A;
    if (onehot[1]) code = SEL_B;
    if (onehot[2]) code = SEL_C;
    return code;
  endfunction

endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// Combinational round-robin picker: the first requester after ptr wins,
// so ptr=A searches B,C,A; ptr=B searches C,A,B; ptr=C searches A,B,C.
module rr_pick3
  import mux3_rr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] pick,
  output logic       any_req
);

  always_comb begin
    pick = 3'b000;
    unique case (ptr)
      SEL_A: begin
        if      (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
      end
      SEL_B: begin
        if      (req[2]) pick = 3'b100;
        else if (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
      end
      default: begin
        if      (req[0]) pick = 3'b001;
        else if (req[1]) pick = 3'b010;
        else if (req[2]) pick = 3'b100;
      end
    endcase
  end

  assign any_req = |req;

endmodule

// File: rtl/mux3_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 3-to-1 data mux: grants one
// requester at a time, drives the select and registers the chosen word.
module mux3_rr_arbiter
  import mux3_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] din_c,
  output logic [2:0]        gnt,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_next;
  logic [2:0]        gnt_next;
  logic [1:0]        sel_next;
  logic [1:0]        rr_ptr, ptr_next;
  logic [HOLD_W-1:0] hold_cnt, hold_next;
  logic [2:0]        others;
  logic [2:0]        pick;
  logic              any_other;
  logic              owner_req;
  logic              xfer;
  logic [DATA_W-1:0] mux_data;

  // Excluding the owner lets one picker serve both hand-off and rotation;
  // in IDLE gnt is zero so this is simply req.
  assign others    = req & ~gnt;
  assign owner_req = |(req & gnt);

  rr_pick3 u_pick (
    .req     (others),
    .ptr     (rr_ptr),
    .pick    (pick),
    .any_req (any_other)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gnt        <= 3'b000;
      sel        <= SEL_A;
      rr_ptr     <= SEL_C;
      hold_cnt   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_next;
      gnt        <= gnt_next;
      sel        <= sel_next;
      rr_ptr     <= ptr_next;
      hold_cnt   <= hold_next;
      dout_valid <= xfer;
      if (xfer) dout <= mux_data;
    end
  end

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    sel_next   = sel;
    ptr_next   = rr_ptr;
    hold_next  = hold_cnt;
    unique case (state)
      ST_IDLE: begin
        if (any_other) begin
          state_next = ST_GRANT;
          gnt_next   = pick;
          sel_next   = sel_of(pick);
          ptr_next   = sel_of(pick);
          hold_next  = '0;
        end
      end
      default: begin
        // Dropping the request outranks the hold limit, and a hand-off to a
        // waiting requester never passes through IDLE.
        if ((!owner_req || hold_cnt == HOLD_MAX) && any_other) begin
          gnt_next  = pick;
          sel_next  = sel_of(pick);
          ptr_next  = sel_of(pick);
          hold_next = '0;
        end else if (!owner_req) begin
          state_next = ST_IDLE;
          gnt_next   = 3'b000;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    xfer = |(gnt & req);
    unique case (sel)
      SEL_B:   mux_data = din_b;
      SEL_C:   mux_data = din_c;
      default: mux_data = din_a;
    endcase
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Directed self-checking bench for mux3_rr_arbiter with a randomised
// fairness soak at the end.
module tb_mux3_rr_arbiter;

  localparam int DATA_W   = 3;
  localparam int MAX_HOLD = 4;

  logic              clk;
  logic              rst;
  logic [2:0]        req;
  logic [DATA_W-1:0] din_a, din_b, din_c;
  logic [2:0]        gnt;
  logic [1:0]        sel;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;

  int compared;
  int mismatched;

  mux3_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din_a      (din_a),
    .din_b      (din_b),
    .din_c      (din_c),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] data_of(input logic [2:0] owner);
    logic [2:0] d;
    d = 3'b101;
    if (owner == 3'b010) d = 3'b010;
    if (owner == 3'b100) d = 3'b110;
    return d;
  endfunction

  function automatic logic [1:0] sel_exp(input logic [2:0] owner);
    logic [1:0] s;
    s = 2'b00;
    if (owner == 3'b010) s = 2'b01;
    if (owner == 3'b100) s = 2'b10;
    return s;
  endfunction

  initial begin
    logic [2:0] exp_gnt, prev_gnt;
    int wait_cnt [3];
    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    req   = 3'b000;
    din_a = 3'b101;
    din_b = 3'b010;
    din_c = 3'b110;
    tick();
    checkOutput("reset_gnt",   32'(gnt), 32'h0);
    checkOutput("reset_sel",   32'(sel), 32'h0);
    checkOutput("reset_dout",  32'(dout), 32'h0);
    checkOutput("reset_valid", 32'(dout_valid), 32'h0);

    // Full contention: 4 cycles each A, B, C, then back to A.
    rst = 1'b0;
    req = 3'b111;
    prev_gnt = 3'b000;
    for (int k = 1; k <= 13; k++) begin
      tick();
      exp_gnt = (k <= 4) ? 3'b001 : (k <= 8) ? 3'b010 : (k <= 12) ? 3'b100 : 3'b001;
      checkOutput($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(exp_gnt));
      checkOutput($sformatf("rot_sel%0d", k), 32'(sel), 32'(sel_exp(exp_gnt)));
      checkOutput($sformatf("rot_valid%0d", k), 32'(dout_valid), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2)
        checkOutput($sformatf("rot_dout%0d", k), 32'(dout), 32'(data_of(prev_gnt)));
      prev_gnt = exp_gnt;
    end
    req = 3'b000;
    tick();
    checkOutput("drop_valid", 32'(dout_valid), 32'h0);
    checkOutput("drop_dout",  32'(dout), 32'(3'b110));
    checkOutput("drop_gnt",   32'(gnt), 32'h0);
    checkOutput("drop_sel",   32'(sel), 32'h0);

    // Lone requester B keeps its grant indefinitely.
    req = 3'b010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("lone_gnt%0d", k), 32'(gnt), 32'(3'b010));
      checkOutput($sformatf("lone_sel%0d", k), 32'(sel), 32'(2'b01));
      checkOutput($sformatf("lone_valid%0d", k), 32'(dout_valid), (k >= 2) ? 32'h1 : 32'h0);
      if (k >= 2) checkOutput($sformatf("lone_dout%0d", k), 32'(dout), 32'(3'b010));
    end

    // Owner drops while another waits: direct hand-off, no idle bubble.
    req = 3'b001;
    tick();
    checkOutput("hand_b2a_gnt", 32'(gnt), 32'(3'b001));
    req = 3'b101;
    tick();
    checkOutput("keep_a_gnt", 32'(gnt), 32'(3'b001));
    req = 3'b100;
    tick();
    checkOutput("hand_a2c_gnt", 32'(gnt), 32'(3'b100));
    checkOutput("hand_a2c_sel", 32'(sel), 32'(2'b10));

    // Asynchronous reset in the middle of a B grant.
    req = 3'b010;
    tick();
    checkOutput("pre_rst_gnt", 32'(gnt), 32'(3'b010));
    tick();
    checkOutput("pre_rst_valid", 32'(dout_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_gnt",   32'(gnt), 32'h0);
    checkOutput("async_valid", 32'(dout_valid), 32'h0);
    checkOutput("async_dout",  32'(dout), 32'h0);
    checkOutput("async_sel",   32'(sel), 32'h0);
    tick();
    rst = 1'b0;
    req = 3'b111;
    tick();
    checkOutput("post_rst_gnt", 32'(gnt), 32'(3'b001));
    checkOutput("post_rst_sel", 32'(sel), 32'(2'b00));

    // Randomised soak: requesters hold until served, owners drop at random.
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    req = 3'b000;
    for (int c = 0; c < 2000; c++) begin
      tick();
      checkOutput("soak_onehot", 32'($onehot0(gnt)), 32'h1);
      checkOutput("soak_sel", (sel == 2'b11) ? 32'h1 : 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > 2 * MAX_HOLD + 1)
          checkOutput($sformatf("starve_%0d", i), 32'(wait_cnt[i]), 32'(2 * MAX_HOLD + 1));
      end
      for (int i = 0; i < 3; i++) begin
        if (gnt[i] && req[i]) begin
          if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
        end else if (!req[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
